sram_confreg: RTL
=================

# sram_confreg

Memory-mapped configuration/timer peripheral that sits on the responder side of the CPU's SRAM-like data port (en / wen / addr / wdata / rdata), behind the data-side address mapping. It decodes one 64 KiB window, holds LED, switch, scratch and timer registers, and returns read data with fixed one-cycle synchronous-SRAM latency. It also raises the timer interrupt that feeds the CPU's external interrupt inputs.

## Interface
- BASE_HI, 16'h1faf, physical address bits [31:16] that select this block
- LED_W, 16, implemented LED register width (1..32)
- SW_W, 8, implemented switch input width (1..32)

- clk  in  1  sole clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  access request this cycle
- wen  in  4  byte write enables; 4'b0000 with en=1 is a read
- addr  in  32  physical byte address; bits [1:0] ignored
- wdata  in  32  write data, byte lane i = wdata[8i+7:8i]
- rdata  out  32  registered read data
- sw  in  SW_W  asynchronous switch inputs
- led  out  LED_W  LED register contents
- timer_int  out  1  registered level interrupt

## Operation
- Hit = en & (addr[31:16] == BASE_HI); offset = addr[15:0]. Miss or unmapped offset: write ignored, read returns 32'h0.
- Register map (unused upper bits read 0, ignore writes):
  - 0x00 LED, RW, LED_W bits, drives led.
  - 0x04 SWITCH, RO, sw passed through a 2-flop synchronizer; writes ignored.
  - 0x08 COUNT, RW, 32-bit free-running, +1 every cycle, wraps 32'hffffffff -> 0.
  - 0x0C COMPARE, RW, 32 bits.
  - 0x10 STATUS, bit0 = pending; write 1 clears, write 0 no effect.
  - 0x14 CTRL, RW, bit0 = interrupt enable.
  - 0x18 SCRATCH, RW, 32 bits.
- Writes honour wen per byte, including partial COUNT/COMPARE writes; unwritten bytes keep value (COUNT's unwritten bytes take the incremented value).
- Match: pending set on the edge where the pre-edge COUNT == COMPARE and COMPARE != 0.
- timer_int = registered (pending & enable).

## Timing
- Reset: rdata=0, led=0, COUNT=0, COMPARE=0, pending=0, enable=0, SCRATCH=0, synchronizer=0, timer_int=0. Reset mid-access discards the access.
- Read: en=1, wen=0 at edge N -> rdata valid after edge N+1 (one cycle), holds until next read. No stall, no back-pressure; back-to-back reads every cycle.
- Write (en=1, wen!=0): takes effect at that edge; rdata unchanged.
- Read-before-write: a read sees state before the edge at which it is sampled; COUNT read returns pre-increment value of that cycle.
- COUNT write and increment same edge: written bytes win.
- Match and STATUS W1C same edge: set wins, pending stays 1.
- Match to timer_int: pending set at edge M, timer_int high after edge M+1. Clear/disable drops timer_int one edge after pending/enable falls.
- sw change to SWITCH readable: 2 edges of synchronizer, plus read latency.

## Structure
- Shared package: BASE_HI default, register offsets (OFF_LED..OFF_SCRATCH), STATUS/CTRL bit indices.
- One sub-module: sync2 (parameterised-width two-flop synchronizer, async active-high reset) for sw.

## Test plan
- Reset, then read all offsets -> all return 0, led=0, timer_int=0.
- Write LED 32'h0000_a5a5 wen=4'b0001 -> read LED returns 32'h0000_00a5, led=16'h00a5.
- Hold sw=8'h3c, wait 3 cycles, read SWITCH -> 32'h0000_003c; write SWITCH -> still 32'h3c.
- Write COMPARE=32'd20, CTRL=1, COUNT=32'd10 -> pending set when COUNT passes 20, timer_int high one cycle later; write STATUS=1 -> timer_int falls; COMPARE=0 never fires.
- COUNT=32'hffff_fffe, read twice consecutively -> 32'hffff_ffff then wrap to 0; addr 32'h1fb0_0008 write ignored, read 0.
- Force W1C of STATUS on the match edge -> pending stays 1; assert rst mid-read -> rdata 0 immediately.

Source files
------------

// File: rtl/sram_confreg_pkg.sv
// sram_confreg_pkg: shared constants for the SRAM-port configuration/timer
// peripheral. Holds the default address window, the register offset map,
// the STATUS/CTRL bit positions and a byte-lane merge helper.
package sram_confreg_pkg;

  // Physical address bits [31:16] decoded by default.
  localparam logic [15:0] BASE_HI_DEF = 16'h1faf;

  // Word-aligned register offsets within the 64 KiB window.
  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_SWITCH  = 16'h0004;
  localparam logic [15:0] OFF_COUNT   = 16'h0008;
  localparam logic [15:0] OFF_COMPARE = 16'h000c;
  localparam logic [15:0] OFF_STATUS  = 16'h0010;
  localparam logic [15:0] OFF_CTRL    = 16'h0014;
  localparam logic [15:0] OFF_SCRATCH = 16'h0018;

  // Bit positions inside STATUS and CTRL.
  localparam int unsigned STATUS_PENDING_BIT = 0;
  localparam int unsigned CTRL_IE_BIT        = 0;

  // Replace the byte lanes of old_v selected by be with those of new_v.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_confreg_sync2.sv
// sram_confreg_sync2: parameterised-width two-flop synchronizer with
// asynchronous active-high reset.
//   clk  in   sampling clock
//   rst  in   asynchronous active-high reset (both stages clear to 0)
//   d    in   W-bit asynchronous input
//   q    out  W-bit synchronized output (two clk edges of latency)
module sram_confreg_sync2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sram_confreg.sv
// sram_confreg: memory-mapped LED / switch / scratch / timer peripheral on
// the responder side of an SRAM-like data port. Reads return data one cycle
// after the request edge; writes take effect at the request edge.
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   access request this cycle
//   wen[3:0]   in   byte write enables; 0 with en=1 is a read
//   addr[31:0] in   physical byte address; [31:16] selects block, [1:0] ignored
//   wdata[31:0]in   write data
//   rdata[31:0]out  registered read data (0 for miss / unmapped offset)
//   sw         in   asynchronous switch inputs (SW_W bits)
//   led        out  LED register (LED_W bits)
//   timer_int  out  registered (pending & enable)
module sram_confreg
  import sram_confreg_pkg::*;
#(
  parameter logic [15:0] BASE_HI = BASE_HI_DEF,
  parameter int unsigned LED_W   = 16,
  parameter int unsigned SW_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       wen,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic             timer_int
);

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic             pending_q, pending_d;
  logic             enable_q, enable_d;
  logic [31:0]      scratch_q, scratch_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             timer_int_q, timer_int_d;

  logic [SW_W-1:0]  sw_sync;
  logic [31:0]      led_ext;
  logic [31:0]      sw_ext;
  logic [15:0]      off;
  logic             hit;
  logic             wr;
  logic             rd;
  logic             match;
  logic [31:0]      count_inc;
  logic [31:0]      rd_val;
  logic             unused_addr_lsbs;

  sram_confreg_sync2 #(.W(SW_W)) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw),
    .q   (sw_sync)
  );

  assign unused_addr_lsbs = ^addr[1:0];

  always_comb begin
    led_ext = '0;
    led_ext[LED_W-1:0] = led_q;
    sw_ext = '0;
    sw_ext[SW_W-1:0] = sw_sync;
  end

  always_comb begin
    hit       = en && (addr[31:16] == BASE_HI);
    off       = {addr[15:2], 2'b00};
    wr        = hit && (wen != 4'b0000);
    // Misses with wen=0 still count as reads so that they return 0.
    rd        = en && (wen == 4'b0000);
    count_inc = count_q + 32'd1;
    match     = (count_q == compare_q) && (compare_q != '0);
  end

  // Read mux: sees register state before the sampling edge.
  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (off)
        OFF_LED:     rd_val = led_ext;
        OFF_SWITCH:  rd_val = sw_ext;
        OFF_COUNT:   rd_val = count_q;
        OFF_COMPARE: rd_val = compare_q;
        OFF_STATUS:  rd_val[STATUS_PENDING_BIT] = pending_q;
        OFF_CTRL:    rd_val[CTRL_IE_BIT] = enable_q;
        OFF_SCRATCH: rd_val = scratch_q;
        default:     rd_val = '0;
      endcase
    end
  end

  always_comb begin
    led_d       = led_q;
    count_d     = count_inc;
    compare_d   = compare_q;
    pending_d   = pending_q;
    enable_d    = enable_q;
    scratch_d   = scratch_q;
    rdata_d     = rdata_q;
    timer_int_d = pending_q && enable_q;

    if (rd) rdata_d = rd_val;

    if (wr) begin
      case (off)
        OFF_LED:     led_d     = LED_W'(byte_merge(led_ext, wdata, wen));
        // Unwritten COUNT bytes carry the incremented value.
        OFF_COUNT:   count_d   = byte_merge(count_inc, wdata, wen);
        OFF_COMPARE: compare_d = byte_merge(compare_q, wdata, wen);
        OFF_STATUS: begin
          if (wen[STATUS_PENDING_BIT / 8] && wdata[STATUS_PENDING_BIT])
            pending_d = 1'b0;
        end
        OFF_CTRL: begin
          if (wen[CTRL_IE_BIT / 8]) enable_d = wdata[CTRL_IE_BIT];
        end
        OFF_SCRATCH: scratch_d = byte_merge(scratch_q, wdata, wen);
        default: ;
      endcase
    end

    // A match on the same edge as a W1C keeps pending set.
    if (match) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q       <= '0;
      count_q     <= '0;
      compare_q   <= '0;
      pending_q   <= 1'b0;
      enable_q    <= 1'b0;
      scratch_q   <= '0;
      rdata_q     <= '0;
      timer_int_q <= 1'b0;
    end else begin
      led_q       <= led_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      scratch_q   <= scratch_d;
      rdata_q     <= rdata_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign rdata     = rdata_q;
  assign led       = led_q;
  assign timer_int = timer_int_q;

endmodule
